sram_bus_responder: RTL and testbench

- Responder end of the core-side memory request interface (read/write/addr/writedata in; readdata/finished out) used by the record, play, mix and pitch cores.
- Serves each 32-bit request from the 16-bit off-chip SRAM as two half-word accesses.
- Returns a one-cycle finished pulse per request.
- Sits beside the SDRAM bus as the SRAM-backed store behind the core request mux.

---
 rtl/sram_bus_responder.sv | 179 +++++++++++++++++
 tb/tb_sram_bus_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_responder.sv
// sram_bus_responder: serves 32-bit core requests from a 16-bit async SRAM.
// Each request becomes a low then a high half-word access, then a finished pulse.
module sram_bus_responder #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned ADDR_LIMIT    = 524288
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        sram_read,
   input  logic        sram_write,
   input  logic [22:0] sram_addr,
   input  logic [31:0] sram_writedata,
   output logic [31:0] sram_readdata,
   output logic        sram_finished,
   output logic        sram_busy,
   output logic        sram_error,
   inout  wire  [15:0] SRAM_DQ,
   output logic [19:0] SRAM_ADDR,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE,
      S_RECOVER
   } state_t;

   localparam logic [3:0]  LAST    = 4'(ACCESS_CYCLES - 1);
   localparam logic [3:0]  PRELAST = 4'(ACCESS_CYCLES - 2);
   localparam logic [31:0] LIMIT   = 32'(ADDR_LIMIT);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_wr;
   logic [18:0] r_addr;
   logic [31:0] r_wdata;
   logic [15:0] r_rd_lo;
   logic [31:0] r_rdata;
   logic        r_fin;
   logic        r_err;
   logic        r_busy;
   logic [19:0] r_sa;
   logic        r_oe_n;
   logic        r_we_n;
   logic        r_ce_n;
   logic        r_ub_n;
   logic        r_lb_n;
   logic        r_dq_oe;
   logic [15:0] r_dq_out;

   logic        w_req;
   logic        w_oor;

   assign w_req = sram_read | sram_write;
   assign w_oor = ({9'd0, sram_addr} >= LIMIT);

   // The bus is only driven during write phases, where OE_N is held high.
   assign SRAM_DQ = r_dq_oe ? r_dq_out : 16'bz;

   assign sram_readdata = r_rdata;
   assign sram_finished = r_fin;
   assign sram_error    = r_err;
   assign sram_busy     = r_busy;
   assign SRAM_ADDR     = r_sa;
   assign SRAM_OE_N     = r_oe_n;
   assign SRAM_WE_N     = r_we_n;
   assign SRAM_CE_N     = r_ce_n;
   assign SRAM_UB_N     = r_ub_n;
   assign SRAM_LB_N     = r_lb_n;

   // Request sequencer with registered SRAM strobes; WE_N rises a cycle early for hold.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rd_lo  <= '0;
         r_rdata  <= '0;
         r_fin    <= 1'b0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
         r_sa     <= '0;
         r_oe_n   <= 1'b1;
         r_we_n   <= 1'b1;
         r_ce_n   <= 1'b1;
         r_ub_n   <= 1'b1;
         r_lb_n   <= 1'b1;
         r_dq_oe  <= 1'b0;
         r_dq_out <= '0;
      end else begin
         r_fin <= 1'b0;
         r_err <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_wr    <= sram_write;
                  r_addr  <= sram_addr[18:0];
                  r_wdata <= sram_writedata;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  if (w_oor) begin
                     r_state <= S_DONE;
                     r_fin   <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state  <= S_LO;
                     r_sa     <= {sram_addr[18:0], 1'b0};
                     r_ce_n   <= 1'b0;
                     r_ub_n   <= 1'b0;
                     r_lb_n   <= 1'b0;
                     r_oe_n   <= sram_write;
                     r_we_n   <= ~sram_write;
                     r_dq_oe  <= sram_write;
                     r_dq_out <= sram_writedata[15:0];
                  end
               end
            end
            S_LO: begin
               if (r_cnt == LAST) begin
                  r_cnt    <= '0;
                  r_state  <= S_HI;
                  r_sa     <= {r_addr, 1'b1};
                  r_we_n   <= ~r_wr;
                  r_dq_out <= r_wdata[31:16];
                  if (!r_wr) begin
                     r_rd_lo <= SRAM_DQ;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == PRELAST) begin
                     r_we_n <= 1'b1;
                  end
               end
            end
            S_HI: begin
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
                  r_fin   <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_we_n  <= 1'b1;
                  r_ce_n  <= 1'b1;
                  r_ub_n  <= 1'b1;
                  r_lb_n  <= 1'b1;
                  r_dq_oe <= 1'b0;
                  if (!r_wr) begin
                     r_rdata <= {SRAM_DQ, r_rd_lo};
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == PRELAST) begin
                     r_we_n <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_RECOVER;
            end
            S_RECOVER: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_responder.sv
// tb_sram_bus_responder: drives core requests into the responder with an SRAM model.
// A second instance with four-cycle phases covers the slow-SRAM write timing.
module tb_sram_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [22:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        fin;
   logic        busy;
   logic        err;
   wire  [15:0] dq;
   logic [19:0] sa;
   logic        oe_n, we_n, ce_n, ub_n, lb_n;

   logic        rd2 = 1'b0;
   logic        wr2 = 1'b0;
   logic [22:0] addr2 = '0;
   logic [31:0] wdata2 = '0;
   logic [31:0] rdata2;
   logic        fin2;
   logic        busy2;
   logic        err2;
   wire  [15:0] dq2;
   logic [19:0] sa2;
   logic        oe2_n, we2_n, ce2_n, ub2_n, lb2_n;

   int vecs = 0;
   int errs = 0;
   bit arm = 1'b0;

   logic [15:0] sram [0:1048575];
   logic [31:0] exp_mem [int];
   logic [31:0] exp_rd = '0;
   int          waddrs [$];
   logic [35:0] wq2 [$];

   always #5 clk = ~clk;

   sram_bus_responder #(.ACCESS_CYCLES(2), .ADDR_LIMIT(524288)) dut (
      .i_clk(clk), .i_rst(rst_n),
      .sram_read(rd), .sram_write(wr),
      .sram_addr(addr), .sram_writedata(wdata),
      .sram_readdata(rdata), .sram_finished(fin),
      .sram_busy(busy), .sram_error(err),
      .SRAM_DQ(dq), .SRAM_ADDR(sa),
      .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   sram_bus_responder #(.ACCESS_CYCLES(4), .ADDR_LIMIT(524288)) dut2 (
      .i_clk(clk), .i_rst(rst_n),
      .sram_read(rd2), .sram_write(wr2),
      .sram_addr(addr2), .sram_writedata(wdata2),
      .sram_readdata(rdata2), .sram_finished(fin2),
      .sram_busy(busy2), .sram_error(err2),
      .SRAM_DQ(dq2), .SRAM_ADDR(sa2),
      .SRAM_OE_N(oe2_n), .SRAM_WE_N(we2_n), .SRAM_CE_N(ce2_n),
      .SRAM_UB_N(ub2_n), .SRAM_LB_N(lb2_n)
   );

   // Asynchronous SRAM: drives on read, stores on the WE_N rising edge.
   assign dq = (!ce_n && !oe_n && we_n) ? sram[sa] : 16'bz;

   always @(posedge we_n) begin
      if (arm && !ce_n) sram[sa] = dq;
   end

   always @(posedge we2_n) begin
      if (arm && !ce2_n) wq2.push_back({sa2, dq2});
   end

   // Issue one request, wait for finished, then let the responder return to idle.
   task automatic run_req(input bit w, input bit r, input logic [22:0] a,
                          input logic [31:0] d, output int lat, output bit e);
      @(negedge clk);
      wr = w; rd = r; addr = a; wdata = d;
      lat = -1; e = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (fin) begin
            lat = k; e = err;
            break;
         end
      end
      wr = 1'b0; rd = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vecs++;
      if ({we_n, ce_n, oe_n, ub_n, lb_n} !== 5'b11111) begin
         errs++; $display("FAIL reset_ctl got=%b want=11111", {we_n, ce_n, oe_n, ub_n, lb_n});
      end
      rst_n = 1'b1;
      arm = 1'b1;
      @(negedge clk);
      vecs++;
      if ({busy, fin, err} !== 3'b000) begin
         errs++; $display("FAIL reset_flags got=%b want=000", {busy, fin, err});
      end
      vecs++;
      if (rdata !== 32'h0 || sa !== 20'h0) begin
         errs++; $display("FAIL reset_data rd=%h sa=%h want 0", rdata, sa);
      end
   endtask

   task automatic test_write_read();
      int lat; bit e;
      run_req(1'b1, 1'b0, 23'h00012, 32'hDEADBEEF, lat, e);
      exp_mem[32'h12] = 32'hDEADBEEF; waddrs.push_back(32'h12);
      vecs++;
      if (lat !== 5 || e !== 1'b0) begin
         errs++; $display("FAIL wr_lat got=%0d err=%b want=5 err=0", lat, e);
      end
      vecs++;
      if (sram[20'h24] !== 16'hBEEF || sram[20'h25] !== 16'hDEAD) begin
         errs++; $display("FAIL wr_halves got=%h_%h want=dead_beef", sram[20'h25], sram[20'h24]);
      end
      vecs++;
      if (rdata !== exp_rd) begin
         errs++; $display("FAIL wr_rd_keep got=%h want=%h", rdata, exp_rd);
      end
      run_req(1'b0, 1'b1, 23'h00012, 32'h0, lat, e);
      exp_rd = 32'hDEADBEEF;
      vecs++;
      if (lat !== 5 || rdata !== exp_rd) begin
         errs++; $display("FAIL rd_back lat=%0d rd=%h want=5 %h", lat, rdata, exp_rd);
      end
   endtask

   task automatic test_held();
      int pulses [$];
      @(negedge clk);
      sram[20'h24] = 16'h1111;
      sram[20'h25] = 16'h2222;
      rd = 1'b1; addr = 23'h00012;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (fin) pulses.push_back(k);
         if (k == 8) rd = 1'b0;
      end
      exp_rd = 32'h22221111;
      vecs++;
      if (pulses.size() != 2) begin
         errs++; $display("FAIL held_count got=%0d want=2", pulses.size());
      end else begin
         vecs++;
         if (pulses[0] != 5 || pulses[1] != 12) begin
            errs++; $display("FAIL held_spacing got=%0d,%0d want=5,12", pulses[0], pulses[1]);
         end
      end
      vecs++;
      if (rdata !== exp_rd || busy !== 1'b0) begin
         errs++; $display("FAIL held_data rd=%h busy=%b want=%h 0", rdata, busy, exp_rd);
      end
      sram[20'h24] = 16'hBEEF;
      sram[20'h25] = 16'hDEAD;
   endtask

   task automatic test_rw_both();
      int lat; bit e;
      run_req(1'b1, 1'b1, 23'h7FFFF, 32'h12345678, lat, e);
      exp_mem[32'h7FFFF] = 32'h12345678; waddrs.push_back(32'h7FFFF);
      vecs++;
      if (sram[20'hFFFFE] !== 16'h5678 || sram[20'hFFFFF] !== 16'h1234) begin
         errs++; $display("FAIL both_halves got=%h_%h want=1234_5678", sram[20'hFFFFF], sram[20'hFFFFE]);
      end
      vecs++;
      if (lat !== 5 || e !== 1'b0 || rdata !== exp_rd) begin
         errs++; $display("FAIL both_resp lat=%0d e=%b rd=%h want=5 0 %h", lat, e, rdata, exp_rd);
      end
   endtask

   task automatic test_oor();
      int lat = -1;
      bit e = 1'b0;
      bit ce_seen = 1'b0;
      @(negedge clk);
      rd = 1'b1; addr = 23'h080000;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) rd = 1'b0;
         if (!ce_n) ce_seen = 1'b1;
         if (fin && lat < 0) begin lat = k; e = err; end
      end
      vecs++;
      if (lat !== 1 || e !== 1'b1) begin
         errs++; $display("FAIL oor_pulse lat=%0d err=%b want=1 1", lat, e);
      end
      vecs++;
      if (ce_seen || rdata !== exp_rd) begin
         errs++; $display("FAIL oor_side ce_low=%b rd=%h want=0 %h", ce_seen, rdata, exp_rd);
      end
   endtask

   task automatic test_random();
      int lat; bit e;
      int op, a, elat;
      logic [31:0] d;
      bit eerr;
      for (int i = 0; i < 24; i++) begin
         op = int'($urandom_range(0, 3));
         d = $urandom;
         if (op == 3) begin
            a = 32'h80000 + int'($urandom_range(0, 32'h77FFFF));
            run_req(d[0], ~d[0], 23'(a), d, lat, e);
            elat = 1; eerr = 1'b1;
         end else if (op == 2) begin
            a = waddrs[$urandom_range(0, waddrs.size() - 1)];
            run_req(1'b0, 1'b1, 23'(a), d, lat, e);
            exp_rd = exp_mem[a];
            elat = 5; eerr = 1'b0;
         end else begin
            a = int'($urandom_range(0, 32'h7FFFF));
            run_req(1'b1, 1'b0, 23'(a), d, lat, e);
            exp_mem[a] = d; waddrs.push_back(a);
            elat = 5; eerr = 1'b0;
         end
         vecs++;
         if (lat !== elat || e !== eerr || rdata !== exp_rd) begin
            errs++;
            $display("FAIL rand_%0d op=%0d a=%h lat=%0d e=%b rd=%h want %0d %b %h",
                     i, op, a, lat, e, rdata, elat, eerr, exp_rd);
         end
      end
   endtask

   task automatic test_reset_midwrite();
      int n = 0;
      @(negedge clk);
      wr = 1'b1; addr = 23'h00100; wdata = 32'hA5A5_5A5A;
      while (we_n && n < 10) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (we_n !== 1'b0) begin
         errs++; $display("FAIL mid_we_low got=%b want=0", we_n);
      end
      #2 rst_n = 1'b0;
      wr = 1'b0;
      #1;
      vecs++;
      if (we_n !== 1'b1 || ce_n !== 1'b1 || oe_n !== 1'b1) begin
         errs++; $display("FAIL mid_abort we=%b ce=%b oe=%b want=1 1 1", we_n, ce_n, oe_n);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_rd = 32'h0;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || fin !== 1'b0 || rdata !== exp_rd) begin
         errs++; $display("FAIL mid_after busy=%b fin=%b rd=%h want=0 0 0", busy, fin, rdata);
      end
   endtask

   task automatic test_slow_write();
      int runs [$];
      int run = 0;
      int lat = -1;
      logic [31:0] d = $urandom;
      @(negedge clk);
      wr2 = 1'b1; addr2 = 23'h3A5C1; wdata2 = d;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (!we2_n) run++;
         else if (run > 0) begin runs.push_back(run); run = 0; end
         if (fin2 && lat < 0) begin lat = k; wr2 = 1'b0; end
      end
      wr2 = 1'b0;
      vecs++;
      if (lat !== 9) begin
         errs++; $display("FAIL slow_lat got=%0d want=9", lat);
      end
      vecs++;
      if (runs.size() != 2 || runs[0] != 3 || runs[1] != 3) begin
         errs++; $display("FAIL slow_we_runs got=%0d runs want=2x3", runs.size());
      end
      vecs++;
      if (wq2.size() != 2) begin
         errs++; $display("FAIL slow_writes got=%0d want=2", wq2.size());
      end else begin
         vecs++;
         if (wq2[0] !== {20'h74B82, d[15:0]} || wq2[1] !== {20'h74B83, d[31:16]}) begin
            errs++; $display("FAIL slow_hold got=%h,%h want=%h,%h", wq2[0], wq2[1],
                             {20'h74B82, d[15:0]}, {20'h74B83, d[31:16]});
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_held();
      test_rw_both();
      test_oor();
      test_random();
      test_reset_midwrite();
      test_slow_write();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
